// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract unit: CHUNK bits per clock through a registered ripple stage,
// valid/ready on both sides, signed-overflow/zero flags. Optional clamping: ADDSUB_SATURATE_EN.
module addsub_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_o,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
    logic             r_op, r_carry, r_carry_o, r_ovf, r_zero;
    logic [KW-1:0]    r_k;

    logic [CHUNK-1:0] w_a_chunk, w_b_chunk;
    logic [CHUNK:0]   w_chunk_sum;
    logic [WIDTH-1:0] w_acc_next, w_res_sat;
    logic             w_last, w_ovf, w_zero;
    int unsigned      w_shift;

    always_comb begin
        w_shift     = int'(r_k) * CHUNK;
        w_a_chunk   = CHUNK'(r_a >> w_shift);
        w_b_chunk   = CHUNK'(r_b >> w_shift);
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK + 1)'(r_carry);
        // Accumulator is cleared on acceptance, so OR-ing the new chunk in place is enough.
        w_acc_next  = r_acc | (WIDTH'(w_chunk_sum[CHUNK-1:0]) << w_shift);
        w_last      = (r_k == KW'(NCHUNK - 1));
        // r_b already holds ~num2 for subtraction, so this equals carry-in XOR carry-out at MSB.
        w_ovf       = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
        w_zero      = (w_acc_next == '0);
    end

`ifdef ADDSUB_SATURATE_EN
    always_comb begin
        w_res_sat = w_acc_next;
        if (w_ovf) begin
            w_res_sat = r_a[WIDTH-1] ? {1'b1, {(WIDTH - 1){1'b0}}} : {1'b0, {(WIDTH - 1){1'b1}}};
        end
    end
`else
    assign w_res_sat = w_acc_next;
`endif

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (in_valid) w_state_next = StCalc;
            StCalc:  if (w_last) w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_op      <= 1'b0;
            r_carry   <= 1'b0;
            r_k       <= '0;
            r_result  <= '0;
            r_carry_o <= 1'b0;
            r_ovf     <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a     <= num1;
                        r_b     <= op ? ~num2 : num2;
                        r_op    <= op;
                        r_carry <= op;
                        r_k     <= '0;
                        r_acc   <= '0;
                    end
                end
                StCalc: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_chunk_sum[CHUNK];
                    r_k     <= r_k + 1'b1;
                    if (w_last) begin
                        r_result  <= w_res_sat;
                        r_carry_o <= w_chunk_sum[CHUNK] ^ r_op;
                        r_ovf     <= w_ovf;
                        r_zero    <= w_zero;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign result    = r_result;
    assign carry_o   = r_carry_o;
    assign overflow  = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_addsub_seq.sv
// Randomised and directed bench for addsub_seq; three instances cover CHUNK = 8, 1 and 32.
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  iv;
    logic [31:0] num1, num2;
    logic        op, out_ready;

    logic        ir0, ov0, c0, v0, z0;
    logic        ir1, ov1, c1, v1, z1;
    logic        ir2, ov2, c2, v2, z2;
    logic [31:0] r0, r1, r2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0), .num1(num1), .num2(num2),
        .op(op), .out_valid(ov0), .out_ready(out_ready), .result(r0), .carry_o(c0),
        .overflow(v0), .zero(z0)
    );
    addsub_seq #(.WIDTH(32), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1), .num1(num1), .num2(num2),
        .op(op), .out_valid(ov1), .out_ready(out_ready), .result(r1), .carry_o(c1),
        .overflow(v1), .zero(z1)
    );
    addsub_seq #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2), .num1(num1), .num2(num2),
        .op(op), .out_valid(ov2), .out_ready(out_ready), .result(r2), .carry_o(c2),
        .overflow(v2), .zero(z2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int nchunk(input int sel);
        return (sel == 0) ? 4 : (sel == 1) ? 32 : 1;
    endfunction

    task automatic sample(input int sel, output logic rdy, output logic vld,
                          output logic [31:0] res, output logic c, output logic v,
                          output logic z);
        case (sel)
            0:       begin rdy = ir0; vld = ov0; res = r0; c = c0; v = v0; z = z0; end
            1:       begin rdy = ir1; vld = ov1; res = r1; c = c1; v = v1; z = z1; end
            default: begin rdy = ir2; vld = ov2; res = r2; c = c2; v = v2; z = z2; end
        endcase
    endtask

    // Reference: plain unsigned/signed arithmetic on the operands.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic o,
                         output logic [31:0] r, output logic c, output logic v,
                         output logic z);
        logic [32:0] full;
        logic [31:0] raw;
        if (!o) begin
            full = {1'b0, a} + {1'b0, b};
            raw  = full[31:0];
            c    = full[32];
            v    = (a[31] == b[31]) && (raw[31] != a[31]);
        end else begin
            raw = a - b;
            c   = (a < b);
            v   = (a[31] != b[31]) && (raw[31] != a[31]);
        end
        z = (raw == 32'd0);
        r = raw;
`ifdef ADDSUB_SATURATE_EN
        if (v) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    endtask

    task automatic do_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic o, input bit bp);
        logic [31:0] er, res;
        logic        ec, ev, ez, rdy, vld, c, v, z;
        int          lat;
        model(a, b, o, er, ec, ev, ez);
        @(negedge clk);
        num1 = a; num2 = b; op = o; out_ready = !bp; iv[sel] = 1'b1;
        sample(sel, rdy, vld, res, c, v, z);
        check("in_ready_idle", rdy, 1);
        @(posedge clk); #1;
        iv = '0;
        lat = 1;
        sample(sel, rdy, vld, res, c, v, z);
        while (!vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            sample(sel, rdy, vld, res, c, v, z);
        end
        check("latency", lat, nchunk(sel) + 1);
        check("result", res, er);
        check("carry_o", c, ec);
        check("overflow", v, ev);
        check("zero", z, ez);
        if (bp) begin
            repeat (10) begin
                @(negedge clk);
                num1 = $urandom; num2 = $urandom; op = 1'($urandom); iv[sel] = 1'b1;
                @(posedge clk); #1;
                sample(sel, rdy, vld, res, c, v, z);
                check("bp_out_valid", vld, 1);
                check("bp_in_ready", rdy, 0);
                check("bp_result", res, er);
                check("bp_flags", {c, v, z}, {ec, ev, ez});
            end
            @(negedge clk);
            iv = '0; out_ready = 1'b1;
        end
        @(posedge clk); #1;
        sample(sel, rdy, vld, res, c, v, z);
        check("valid_drop", vld, 0);
        check("ready_rise", rdy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic        rdy, vld, c, v, z, seen;
        rst_n = 1'b0; iv = '0; num1 = '0; num2 = '0; op = 1'b0; out_ready = 1'b0;
        #1;
        sample(0, rdy, vld, res, c, v, z);
        check("rst_in_ready", rdy, 1);
        check("rst_out_valid", vld, 0);
        check("rst_outputs", {res, c, v, z}, 35'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0);
        do_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        do_op(0, 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0);

        // Abort after two CALC edges; result currently holds 2 from the previous op.
        @(negedge clk);
        num1 = 32'h1234_5678; num2 = 32'h1; op = 1'b0; out_ready = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sample(0, rdy, vld, res, c, v, z);
        check("abort_outputs", {res, c, v, z}, 35'd0);
        check("abort_out_valid", vld, 0);
        check("abort_in_ready", rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            sample(0, rdy, vld, res, c, v, z);
            if (vld) seen = 1'b1;
        end
        check("abort_no_valid", seen, 0);
        check("abort_idle_ready", rdy, 1);

        for (int s = 0; s < 3; s++) do_op(s, 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0);

        for (int i = 0; i < 30; i++) do_op(0, $urandom, $urandom, 1'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_op(1, $urandom, $urandom, 1'($urandom), 1'b0);
            do_op(2, $urandom, $urandom, 1'($urandom), 1'b0);
        end
        do_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
